// File: rtl/demux4_stream.sv
// demux4_stream: registered 1-to-4 stream demultiplexer with valid/ready handshakes.
// A single producer word, tagged with a 2-bit destination, is captured into a
// one-entry output register and offered to exactly one of four sinks. Per-sink
// saturating transfer counters track completed output handshakes.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_data/in_sel      producer word and destination index
//   in_valid/in_ready   producer handshake
//   out_data            registered word, shared by all sinks
//   out_valid[3:0]      one-hot valid, bit k addresses sink k
//   out_ready[3:0]      per-sink ready
//   clr_counts          synchronous clear of all counters
//   counts              packed counters, port k at [k*CNT_WIDTH +: CNT_WIDTH]

// Per-sink saturating transfer counter; clear wins over increment.
module demux4_stream_cnt #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 inc,
    output logic [CNT_WIDTH-1:0] count
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (inc && (count != {CNT_WIDTH{1'b1}}))
            count <= count + 1'b1;
    end
endmodule

module demux4_stream #(
    parameter int WIDTH     = 32,
    parameter int CNT_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [WIDTH-1:0]         in_data,
    input  logic [1:0]               in_sel,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [3:0]               out_valid,
    input  logic [3:0]               out_ready,
    input  logic                     clr_counts,
    output logic [4*CNT_WIDTH-1:0]   counts
);
    typedef enum logic {EMPTY, FULL} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   data_q;
    logic [1:0]         sel_q;
    logic               load;
    logic               sel_ready;
    logic               in_hs;
    logic               out_hs;

    // Only the addressed sink's ready matters; in_ready never looks at in_valid.
    assign sel_ready = out_ready[sel_q];
    assign in_ready  = (state_q == EMPTY) || sel_ready;
    assign in_hs     = in_valid && in_ready;
    assign out_hs    = (state_q == FULL) && sel_ready;

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        case (state_q)
            EMPTY: begin
                if (in_hs) begin
                    state_d = FULL;
                    load    = 1'b1;
                end
            end
            FULL: begin
                if (out_hs) begin
                    // Drain and refill in the same cycle keeps full throughput.
                    if (in_hs) load = 1'b1;
                    else       state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            data_q  <= '0;
            sel_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            if (load) begin
                data_q <= in_data;
                sel_q  <= in_sel;
            end
        end
    end

    assign out_data  = data_q;
    assign out_valid = (state_q == FULL) ? (4'b0001 << sel_q) : 4'b0000;

    for (genvar k = 0; k < 4; k++) begin : g_cnt
        demux4_stream_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .clr   (clr_counts),
            .inc   (out_hs && (sel_q == 2'(k))),
            .count (counts[k*CNT_WIDTH +: CNT_WIDTH])
        );
    end
endmodule

// File: tb/tb_demux4_stream.sv
// Directed and randomized bench for demux4_stream, built with 4-bit counters
// so that saturation is reachable in a short run.
module tb_demux4_stream;
    localparam int W  = 32;
    localparam int CW = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [W-1:0]    in_data;
    logic [1:0]      in_sel;
    logic            in_valid;
    logic            in_ready;
    logic [W-1:0]    out_data;
    logic [3:0]      out_valid;
    logic [3:0]      out_ready;
    logic            clr_counts;
    logic [4*CW-1:0] counts;

    int checks = 0;
    int errors = 0;

    demux4_stream #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .clr_counts (clr_counts),
        .counts     (counts)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_counts;
        clr_counts = 1'b1;
        tick();
        clr_counts = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; in_data = '0; in_sel = 2'd0; in_valid = 1'b0;
        out_ready = 4'b0000; clr_counts = 1'b0;
        #12;
        checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL reset_out_valid got %b want 0000", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        checks++; if (counts !== 16'h0000) begin errors++; $display("FAIL reset_counts got %h want 0000", counts); end
        checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data got %h want 0", out_data); end
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_single;
        in_data = 32'hDEADBEEF; in_sel = 2'd2; in_valid = 1'b1; out_ready = 4'hF;
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 4'b0100) begin errors++; $display("FAIL single_valid got %b want 0100", out_valid); end
        checks++; if (out_data !== 32'hDEADBEEF) begin errors++; $display("FAIL single_data got %h want deadbeef", out_data); end
        tick();
        checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL single_valid_drop got %b want 0000", out_valid); end
        checks++; if (counts !== 16'h0100) begin errors++; $display("FAIL single_counts got %h want 0100", counts); end
        checks++; if (out_data !== 32'hDEADBEEF) begin errors++; $display("FAIL single_data_hold got %h want deadbeef", out_data); end
    endtask

    task automatic test_back_to_back;
        clear_counts();
        out_ready = 4'hF; in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_data = 32'h100 + i; in_sel = 2'(i % 4);
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready[%0d] got %b want 1", i, in_ready); end
            tick();
            checks++; if (out_valid !== (4'b0001 << (i % 4))) begin errors++; $display("FAIL b2b_valid[%0d] got %b want %b", i, out_valid, 4'b0001 << (i % 4)); end
            checks++; if (out_data !== 32'h100 + i) begin errors++; $display("FAIL b2b_data[%0d] got %h want %h", i, out_data, 32'h100 + i); end
        end
        in_valid = 1'b0;
        tick();
        checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL b2b_drain got %b want 0000", out_valid); end
        checks++; if (counts !== 16'h2222) begin errors++; $display("FAIL b2b_counts got %h want 2222", counts); end
    endtask

    task automatic test_backpressure;
        clear_counts();
        out_ready = 4'b1101; in_data = 32'hA5A5A5A5; in_sel = 2'd1; in_valid = 1'b1;
        tick();
        in_data = 32'h12345678; in_sel = 2'd3;
        for (int i = 0; i < 5; i++) begin
            checks++; if (out_valid !== 4'b0010) begin errors++; $display("FAIL bp_valid[%0d] got %b want 0010", i, out_valid); end
            checks++; if (out_data !== 32'hA5A5A5A5) begin errors++; $display("FAIL bp_data[%0d] got %h want a5a5a5a5", i, out_data); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d] got %b want 0", i, in_ready); end
            tick();
        end
        out_ready = 4'hF;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 4'b1000) begin errors++; $display("FAIL bp_next_valid got %b want 1000", out_valid); end
        checks++; if (out_data !== 32'h12345678) begin errors++; $display("FAIL bp_next_data got %h want 12345678", out_data); end
        tick();
        checks++; if (counts !== 16'h1010) begin errors++; $display("FAIL bp_counts got %h want 1010", counts); end
    endtask

    task automatic test_saturate;
        clear_counts();
        out_ready = 4'hF; in_sel = 2'd3; in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_data = 32'h3000 + i;
            tick();
        end
        in_valid = 1'b0;
        tick();
        checks++; if (counts !== 16'hF000) begin errors++; $display("FAIL sat_counts got %h want f000", counts); end
        in_valid = 1'b1; in_data = 32'h77; in_sel = 2'd3;
        tick();
        in_valid = 1'b0; clr_counts = 1'b1;
        checks++; if (out_valid !== 4'b1000) begin errors++; $display("FAIL clr_pre_valid got %b want 1000", out_valid); end
        tick();
        clr_counts = 1'b0;
        checks++; if (counts !== 16'h0000) begin errors++; $display("FAIL clr_hs_counts got %h want 0000", counts); end
        checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL clr_hs_valid got %b want 0000", out_valid); end
    endtask

    task automatic test_reset_midflight;
        clear_counts();
        out_ready = 4'b1110; in_valid = 1'b1; in_data = 32'h11; in_sel = 2'd1;
        tick();
        in_data = 32'h22; in_sel = 2'd0;
        tick();
        in_valid = 1'b0;
        tick();
        checks++; if (out_valid !== 4'b0001) begin errors++; $display("FAIL mid_stall_valid got %b want 0001", out_valid); end
        checks++; if (counts !== 16'h0010) begin errors++; $display("FAIL mid_pre_counts got %h want 0010", counts); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL mid_async_valid got %b want 0000", out_valid); end
        checks++; if (counts !== 16'h0000) begin errors++; $display("FAIL mid_async_counts got %h want 0000", counts); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_async_ready got %b want 1", in_ready); end
        tick();
        rst_n = 1'b1; out_ready = 4'hF;
        tick();
        checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL mid_post_valid got %b want 0000", out_valid); end
        checks++; if (counts !== 16'h0000) begin errors++; $display("FAIL mid_post_counts got %h want 0000", counts); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_post_ready got %b want 1", in_ready); end
    endtask

    task automatic test_stress;
        logic [33:0] q[$];
        logic [33:0] e;
        logic [3:0]  mc[4];
        logic [4*CW-1:0] mpack;
        int bad = 0;
        clear_counts();
        for (int k = 0; k < 4; k++) mc[k] = '0;
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_sel    = 2'($urandom_range(0, 3));
            in_data   = $urandom;
            out_ready = 4'($urandom);
            #1;
            if ($countones(out_valid) > 1) bad++;
            if (in_ready !== ((out_valid == 4'b0000) || ((out_valid & out_ready) != 4'b0000))) bad++;
            if ((out_valid & out_ready) != 4'b0000) begin
                if (q.size() == 0) bad++;
                else begin
                    e = q.pop_front();
                    if (out_valid !== (4'b0001 << e[33:32]) || out_data !== e[31:0]) bad++;
                    if (mc[e[33:32]] != 4'hF) mc[e[33:32]] = mc[e[33:32]] + 4'd1;
                end
            end
            if (in_valid && in_ready) q.push_back({in_sel, in_data});
            if (q.size() > 1) bad++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0; out_ready = 4'hF;
        #1;
        if ((out_valid & out_ready) != 4'b0000) begin
            if (q.size() == 0) bad++;
            else begin
                e = q.pop_front();
                if (out_valid !== (4'b0001 << e[33:32]) || out_data !== e[31:0]) bad++;
                if (mc[e[33:32]] != 4'hF) mc[e[33:32]] = mc[e[33:32]] + 4'd1;
            end
        end
        tick();
        mpack = {mc[3], mc[2], mc[1], mc[0]};
        checks++; if (bad != 0) begin errors++; $display("FAIL stress_scoreboard got %0d violations want 0", bad); end
        checks++; if (q.size() != 0) begin errors++; $display("FAIL stress_leftover got %0d words want 0", q.size()); end
        checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL stress_drain got %b want 0000", out_valid); end
        checks++; if (counts !== mpack) begin errors++; $display("FAIL stress_counts got %h want %h", counts, mpack); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_saturate();
        test_reset_midflight();
        test_stress();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
